inst_fetch_unit: RTL and testbench

Instruction fetch stage for the RISC-V core. Holds the PC and issues word requests to instruction memory. It buffers one returned instruction and presents it, with its 5-bit opcode field, to the control unit and decode through a valid/ready handshake. Branch redirects from execute retarget the PC and flush any in-flight or buffered instruction.

---
 rtl/inst_fetch_unit.sv | 121 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: holds the PC, requests words from instruction memory,
// buffers one instruction toward decode and honours branch redirects from execute.
module inst_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [4:0]        out_opcode,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_illegal,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  state_t            state_r, state_n;
  logic [ADDR_W-1:0] pc_r, pc_n;
  logic              valid_r, valid_n;
  logic [31:0]       inst_r, inst_n;
  logic [ADDR_W-1:0] inst_pc_r, inst_pc_n;
  logic [31:0]       count_r, count_n;
  logic [ADDR_W-1:0] target_s;
  logic [ADDR_W-1:0] pc_inc_s;

  assign target_s = {br_target[ADDR_W-1:2], 2'b00};
  assign pc_inc_s = pc_r + {{(ADDR_W-3){1'b0}}, 3'b100};

  assign imem_req    = (state_r == FETCH);
  assign imem_addr   = pc_r;
  assign out_valid   = valid_r;
  assign out_inst    = inst_r;
  assign out_pc      = inst_pc_r;
  assign out_opcode  = inst_r[6:2];
  assign out_illegal = (inst_r[1:0] != 2'b11);
  assign fetch_count = count_r;

  // Next-state and datapath update; a redirect outranks every state action.
  always_comb begin
    state_n   = state_r;
    pc_n      = pc_r;
    valid_n   = valid_r;
    inst_n    = inst_r;
    inst_pc_n = inst_pc_r;
    count_n   = count_r;
    if (br_taken) begin
      // A buffered instruction is dropped, but a same-cycle accept still counts.
      pc_n    = target_s;
      valid_n = 1'b0;
      state_n = FETCH;
      if ((state_r == HOLD) && out_ready) begin
        count_n = count_r + 32'd1;
      end else begin
        count_n = count_r;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_n = FETCH;
        end
        FETCH: begin
          if (imem_ready) begin
            inst_n    = imem_rdata;
            inst_pc_n = pc_r;
            valid_n   = 1'b1;
            pc_n      = pc_inc_s;
            state_n   = HOLD;
          end else begin
            state_n = FETCH;
          end
        end
        HOLD: begin
          if (out_ready) begin
            valid_n = 1'b0;
            count_n = count_r + 32'd1;
            state_n = FETCH;
          end else begin
            state_n = HOLD;
          end
        end
        default: begin
          state_n = IDLE;
          valid_n = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      pc_r      <= RESET_PC;
      valid_r   <= 1'b0;
      inst_r    <= 32'h0000_0000;
      inst_pc_r <= {ADDR_W{1'b0}};
      count_r   <= 32'h0000_0000;
    end else begin
      state_r   <= state_n;
      pc_r      <= pc_n;
      valid_r   <= valid_n;
      inst_r    <= inst_n;
      inst_pc_r <= inst_pc_n;
      count_r   <= count_n;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized scoreboard bench for inst_fetch_unit against a transaction-level model.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [4:0]  out_opcode;
  logic [31:0] out_pc;
  logic        out_illegal;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] fetch_count;

  inst_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_opcode(out_opcode), .out_pc(out_pc),
    .out_illegal(out_illegal),
    .br_taken(br_taken), .br_target(br_target),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } item_t;

  item_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          started = 1'b0;

  // Reference model: the unit either waits one cycle after reset, holds one
  // instruction for decode, or is requesting the word at m_pc.
  bit          m_idle = 1'b1;
  bit          m_buf  = 1'b0;
  logic [31:0] m_pc   = 32'h0000_0000;
  logic [31:0] m_cnt  = 32'h0000_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the inputs that were presented at the edge just passed.
  task automatic model_step();
    if (rst) begin
      m_idle = 1'b1;
      m_buf  = 1'b0;
      m_pc   = 32'h0000_0000;
      m_cnt  = 32'h0000_0000;
      exp_q.delete();
    end else if (br_taken) begin
      if (m_buf && out_ready) m_cnt = m_cnt + 32'd1;
      else if (m_buf && exp_q.size() > 0) void'(exp_q.pop_front());
      m_buf  = 1'b0;
      m_idle = 1'b0;
      m_pc   = {br_target[31:2], 2'b00};
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_buf) begin
      if (out_ready) begin
        m_buf = 1'b0;
        m_cnt = m_cnt + 32'd1;
      end
    end else if (imem_ready) begin
      exp_q.push_back('{inst: imem_rdata, pc: m_pc});
      m_buf = 1'b1;
      m_pc  = m_pc + 32'd4;
    end
  endtask

  task automatic cyc(input logic r, input logic br, input logic [31:0] tgt,
                     input logic mr, input logic orr, input logic [31:0] data);
    @(posedge clk);
    #1;
    model_step();
    started    = 1'b1;
    rst        = r;
    br_taken   = br;
    br_target  = tgt;
    imem_ready = mr;
    out_ready  = orr;
    imem_rdata = data;
  endtask

  // Monitor: compares outputs each cycle and consumes the scoreboard on handshakes.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("imem_req", {31'd0, imem_req}, {31'd0, (!m_idle && !m_buf)});
        chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_buf});
        chk("fetch_count", fetch_count, m_cnt);
        if (m_idle) begin
          chk("reset_out_inst", out_inst, 32'h0000_0000);
          chk("reset_out_pc", out_pc, 32'h0000_0000);
          chk("reset_out_opcode", {27'd0, out_opcode}, 32'h0000_0000);
          chk("reset_out_illegal", {31'd0, out_illegal}, 32'h0000_0001);
        end
        if (m_buf) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'h0000_0000, 32'h0000_0001);
          end else begin
            e = exp_q[0];
            chk("out_inst", out_inst, e.inst);
            chk("out_pc", out_pc, e.pc);
            chk("out_opcode", {27'd0, out_opcode}, {27'd0, e.inst[6:2]});
            chk("out_illegal", {31'd0, out_illegal}, {31'd0, (e.inst[1:0] != 2'b11)});
            if (out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    logic [31:0] d;
    rst = 1'b1; br_taken = 1'b0; br_target = 32'h0; imem_ready = 1'b0;
    out_ready = 1'b0; imem_rdata = 32'h0;
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    // Zero-wait stream of 0x33 with decode always ready: three handshakes.
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0033);
    // lw with two wait cycles, then decode stalls for five cycles.
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_2003);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_2003);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_2003);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_2003);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    // Redirect colliding with a memory response (unit is fetching now).
    cyc(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b0, 32'h0000_0013);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0063);
    // Buffered beq: redirect and accept in the same cycle.
    cyc(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    // Fetch from the top word so the PC wraps to zero.
    cyc(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0013);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    // Reset in the middle of a hold.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0037);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    // Randomized traffic with occasional redirects and resets.
    for (int i = 0; i < 3000; i++) begin
      d = $urandom;
      if ($urandom_range(0, 9) != 0) d[1:0] = 2'b11;
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 11) == 0),
          $urandom,
          ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 2) != 0),
          d);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
